// File: rtl/q_row_fetch.sv
// q_row_fetch: fetches one Q-table row (ACTIONS consecutive words for a state)
// from a 1-cycle-latency RAM and presents it as a packed bus with a one-cycle
// valid pulse. Request handshake is valid/ready; o_data holds between pulses.
module q_row_fetch #(
  parameter int DATA_WIDTH    = 32,
  parameter int ACTIONS       = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int STATE_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_valid,
  input  logic [STATE_WIDTH-1:0]               i_state,
  output logic                                 o_ready,
  output logic                                 o_ram_rd_en,
  output logic [STATE_WIDTH+ACTIONS_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0]                i_ram_data,
  output logic [DATA_WIDTH*ACTIONS-1:0]        o_data,
  output logic                                 o_valid
);

  localparam logic [ACTIONS_WIDTH-1:0] LAST_IDX = ACTIONS_WIDTH'(ACTIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    DONE
  } state_t;

  state_t                               state_q;
  logic [STATE_WIDTH-1:0]               row_state_q;
  logic [ACTIONS_WIDTH-1:0]             cnt_q;
  logic                                 ready_q;
  logic                                 rd_en_q;
  logic [STATE_WIDTH+ACTIONS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH*ACTIONS-1:0]        data_q;
  logic                                 valid_q;

  // Capture pipeline: read strobe and slot index delayed to line up with data.
  logic                                 cap_en_q;
  logic [ACTIONS_WIDTH-1:0]             cap_idx_q;
  logic [DATA_WIDTH*ACTIONS-1:0]        shadow_q;
  logic [DATA_WIDTH*ACTIONS-1:0]        shadow_d;

  assign o_ready     = ready_q;
  assign o_ram_rd_en = rd_en_q;
  assign o_ram_addr  = addr_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;

  // Merge the word returning this cycle into its shadow slot.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    shadow_d = shadow_q;
    if (cap_en_q) begin
      shadow_d[cap_idx_q*DATA_WIDTH +: DATA_WIDTH] = i_ram_data;
    end
  end

  // Delay rd_en/index by one cycle and commit returned words to the shadow buffer.
  always_ff @(posedge clk) begin
    // NOTE: the shadow buffer is reset explicitly so o_data reads 0 after reset
    // and no stale row from an aborted fetch can leak out.
    if (!rst_n) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      shadow_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      cap_en_q  <= rd_en_q;
      cap_idx_q <= cnt_q;
      shadow_q  <= shadow_d;
    end
  end

  // Control FSM with registered outputs: accept, issue ACTIONS reads, drain, publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_state_q <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            row_state_q <= i_state;
            cnt_q       <= '0;
            rd_en_q     <= 1'b1;
            addr_q      <= {i_state, ACTIONS_WIDTH'(0)};
            ready_q     <= 1'b0;
            state_q     <= READ;
          end
        end
        READ: begin
          if (cnt_q == LAST_IDX) begin
            // Last index issued; address is held at its final value.
            rd_en_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q  <= cnt_q + ACTIONS_WIDTH'(1);
            addr_q <= {row_state_q, cnt_q + ACTIONS_WIDTH'(1)};
          end
        end
        WAIT: begin
          // The final word lands this cycle, so publish the merged buffer.
          data_q  <= shadow_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_row_fetch.sv
// Self-checking bench for q_row_fetch: a transaction-level model predicts every
// output cycle by cycle from the acceptance time; directed scenarios pin literals.
module tb_q_row_fetch;

  localparam int DW = 32;
  localparam int A  = 4;
  localparam int AW = 2;
  localparam int SW = 4;
  localparam int RW = DW * A;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          i_valid = 1'b0;
  logic [SW-1:0] i_state = '0;
  logic          o_ready;
  logic          o_ram_rd_en;
  logic [SW+AW-1:0] o_ram_addr;
  logic [DW-1:0] ram_data = '0;
  logic [RW-1:0] o_data;
  logic          o_valid;

  logic [DW-1:0] mem [0:63];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state
  int            acc_cyc = -1;
  logic [SW-1:0] acc_state = '0;
  int            m_d;
  logic          exp_rd    = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_ready = 1'b1;
  logic [SW+AW-1:0] exp_addr = '0;
  logic [RW-1:0] exp_data  = '0;

  logic [SW+AW-1:0] rd_log [$];

  q_row_fetch #(
    .DATA_WIDTH(DW), .ACTIONS(A), .ACTIONS_WIDTH(AW), .STATE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_state(i_state),
    .o_ready(o_ready), .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr),
    .i_ram_data(ram_data), .o_data(o_data), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (o_ram_rd_en) ram_data <= mem[o_ram_addr];
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input logic [SW-1:0] s);
    logic [RW-1:0] r;
    logic [AW-1:0] ai;
    r = '0;
    for (int a = 0; a < A; a++) begin
      ai = AW'(a);
      r[a*DW +: DW] = mem[{s, ai}];
    end
    return r;
  endfunction

  function automatic bit model_ready(input int c);
    return (acc_cyc < 0) || (c >= acc_cyc + A + 3);
  endfunction

  // Model: at each edge decide acceptance/reset, then derive outputs for the new cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      acc_cyc  = -1;
      exp_data = '0;
      exp_addr = '0;
    end else if (i_valid && model_ready(cyc - 1)) begin
      acc_cyc   = cyc - 1;
      acc_state = i_state;
    end
    m_d       = (acc_cyc < 0) ? -1 : cyc - acc_cyc;
    exp_rd    = (m_d >= 1) && (m_d <= A);
    if (exp_rd) exp_addr = {acc_state, AW'(m_d - 1)};
    exp_valid = (m_d == A + 2);
    if (exp_valid) exp_data = row_of(acc_state);
    exp_ready = model_ready(cyc);
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("ready", RW'(o_ready), RW'(exp_ready));
      check("rd_en", RW'(o_ram_rd_en), RW'(exp_rd));
      check("addr", RW'(o_ram_addr), RW'(exp_addr));
      check("valid", RW'(o_valid), RW'(exp_valid));
      check("data", o_data, exp_data);
    end
    if (o_ram_rd_en) rd_log.push_back(o_ram_addr);
  end

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  int t0;
  int at;
  logic [RW-1:0] held;
  logic [RW-1:0] row3_lit;
  logic [RW-1:0] row15_lit;

  initial begin
    row3_lit  = 128'h00000013_00000012_00000011_00000010;
    row15_lit = 128'h00000000_7FFFFFFF_80000000_FFFFFFFF;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int a = 0; a < A; a++) mem[12 + a] = 32'h10 + a;
    mem[60] = 32'hFFFFFFFF;
    mem[61] = 32'h80000000;
    mem[62] = 32'h7FFFFFFF;
    mem[63] = 32'h00000000;

    // Reset for two edges, with a request that must be ignored
    rst_n = 1'b0;
    i_valid = 1'b1;
    i_state = 4'd9;
    repeat (2) @(negedge clk);
    check("rst_valid", RW'(o_valid), '0);
    check("rst_rd_en", RW'(o_ram_rd_en), '0);
    check("rst_data", o_data, '0);
    i_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", RW'(o_ready), RW'(1));

    // Single fetch of state 3
    rd_log.delete();
    i_valid = 1'b1; i_state = 4'd3; t0 = cyc;
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(20, at);
    check("single_lat", RW'(at), RW'(t0 + 6));
    check("single_data", o_data, row3_lit);
    check("single_nrd", RW'(rd_log.size()), RW'(4));
    for (int k = 0; k < 4; k++)
      if (k < rd_log.size()) check("single_addr", RW'(rd_log[k]), RW'(12 + k));

    // Busy request held high during a fetch
    repeat (2) @(negedge clk);
    i_valid = 1'b1; i_state = 4'd3; t0 = cyc;
    @(negedge clk);
    i_state = 4'd5;
    wait_valid(20, at);
    check("busy_lat1", RW'(at), RW'(t0 + 6));
    check("busy_data1", o_data, row3_lit);
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(20, at);
    check("busy_lat2", RW'(at), RW'(t0 + 13));

    // Abort a fetch with reset two cycles after acceptance
    repeat (2) @(negedge clk);
    i_valid = 1'b1; i_state = 4'd15;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_rd_en", RW'(o_ram_rd_en), '0);
    check("abort_data", o_data, '0);
    wait_valid(12, at);
    check("abort_novalid", RW'(at), RW'(-1));

    // Boundary row from state 15
    rd_log.delete();
    i_valid = 1'b1; i_state = 4'd15; t0 = cyc;
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(20, at);
    check("bound_lat", RW'(at), RW'(t0 + 6));
    check("bound_data", o_data, row15_lit);
    for (int k = 0; k < 4; k++)
      if (k < rd_log.size()) check("bound_addr", RW'(rd_log[k]), RW'(60 + k));

    // Hold: a second fetch with new data must not disturb o_data until its pulse
    for (int a = 0; a < A; a++) mem[28 + a] = $urandom;
    held = o_data;
    @(negedge clk);
    i_valid = 1'b1; i_state = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      check("hold_data", o_data, held);
    end
    wait_valid(20, at);
    check("hold_new", o_data, row_of(4'd7));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      i_valid = 1'($urandom_range(0, 1));
      i_state = SW'($urandom);
      rst_n   = ($urandom_range(0, 39) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_row_fetch.md
Q_ROW_FETCH -- requirements
Module: q_row_fetch

Interface
REQ-001 The block SHALL take the parameter DATA_WIDTH, default 32: width of one Q-value.
REQ-002 The block SHALL take the parameter ACTIONS, default 4: actions per state (power of 2).
REQ-003 The block SHALL take the parameter ACTIONS_WIDTH, default 2: log2(ACTIONS).
REQ-004 The block SHALL take the parameter STATE_WIDTH, default 4: state index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port i_valid, input, 1 bit: row-fetch request.
REQ-008 The block SHALL have port i_state, input, STATE_WIDTH bits: state whose Q-row is fetched.
REQ-009 The block SHALL have port o_ready, output, 1 bit: block idle, request acceptable.
REQ-010 The block SHALL have port o_ram_rd_en, output, 1 bit: Q-table read strobe.
REQ-011 The block SHALL have port o_ram_addr, output, STATE_WIDTH+ACTIONS_WIDTH bits: read address {state, action}.
REQ-012 The block SHALL have port i_ram_data, input, DATA_WIDTH bits: RAM read data, valid exactly 1 cycle after o_ram_rd_en.
REQ-013 The block SHALL have port o_data, output, DATA_WIDTH*ACTIONS bits: packed row, action a in bits [a*DATA_WIDTH +: DATA_WIDTH]; feeds the max-finder pipeline input bus.
REQ-014 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse, o_data holds a complete new row.

Function
REQ-015 The block SHALL use an FSM with states IDLE, READ, WAIT, DONE; o_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; i_state SHALL be registered at that edge; the FSM SHALL go to READ with action counter 0.
REQ-017 i_valid while o_ready=0 SHALL be ignored, with no queuing and no effect on the fetch in flight.
REQ-018 In READ, for acceptance edge ending cycle T, cycles T+1..T+ACTIONS SHALL assert o_ram_rd_en=1 with o_ram_addr={latched state, k}, k=0..ACTIONS-1 ascending.
REQ-019 The FSM SHALL leave READ after k=ACTIONS-1 (counter wrap is terminal) and spend one cycle in WAIT (T+ACTIONS+1).
REQ-020 Capture SHALL use a 1-cycle-delayed rd_en/index pipeline: i_ram_data in the cycle after the read of index k SHALL be written into slot k of an internal shadow buffer.
REQ-021 In DONE (cycle T+ACTIONS+2), o_valid SHALL be 1 and o_data SHALL equal the shadow buffer; the next state SHALL be IDLE.
REQ-022 Latency from acceptance edge to o_valid SHALL be ACTIONS+2 cycles; the earliest next acceptance SHALL be in cycle T+ACTIONS+3.
REQ-023 o_data SHALL change only on entry to DONE and SHALL hold stable between o_valid pulses, including while a subsequent fetch is in flight.
REQ-024 o_ram_rd_en SHALL be 0 outside READ; o_ram_addr outside READ SHALL be held at its last value.
REQ-025 Data SHALL pass bit-exact with no sign interpretation or arithmetic.

Reset
REQ-026 On any rising edge with rst_n=0, the block SHALL enter IDLE with o_valid=0, o_ram_rd_en=0, o_ram_addr=0, o_data=0, shadow buffer=0 and counters=0; o_ready SHALL be 1 in the following cycle.
REQ-027 Reset mid-operation (READ/WAIT/DONE) SHALL abort the fetch: no o_valid for it, and no further read strobes.
REQ-028 A request presented in the same cycle as rst_n=0 SHALL NOT be accepted.

Verification (ACTIONS=4, DATA_WIDTH=32, STATE_WIDTH=4; RAM model 1-cycle latency)
REQ-029 Reset: rst_n=0 for 2 cycles -> o_valid=0, o_ram_rd_en=0, o_data=0; o_ready=1 the cycle after release.
REQ-030 Single fetch: RAM[{3,a}]=0x10+a, request state 3 at T -> rd_en in T+1..T+4 with addr 12,13,14,15; o_valid only at T+6; o_data=0x00000013_00000012_00000011_00000010.
REQ-031 Busy request: i_valid held high with i_state=5 during the fetch of state 3 -> state-3 result unaffected; state 5 accepted at T+7, next o_valid at T+13.
REQ-032 Abort: rst_n=0 at T+2 of a fetch -> no o_valid, rd_en=0 from the next cycle, o_data=0; a new request afterwards returns the correct row.
REQ-033 Boundary values: state 15, RAM[60..63]={0xFFFFFFFF,0x80000000,0x7FFFFFFF,0x00000000} -> addr 60..63; o_data slots match bit-exact.
REQ-034 Hold: after the first o_valid, start a second fetch with different data -> o_data unchanged until the second o_valid.
